// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter. Sends SYNC_COUNT comma characters after reset so the far-end
// receiver can lock, then shifts payload bytes out MSB-first, filling idle byte slots with COM.
module paralelo_serial #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       data_out,
  output logic       active
);

  typedef enum logic [0:0] {
    StSync,
    StRun
  } state_e;

  // Value sync_cnt_q holds when the last comma of the sync burst is being loaded.
  localparam logic [3:0] SyncLast = 4'(SYNC_COUNT - 1);

  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       active_q, active_d;
  logic       load_edge;

  // A byte boundary: the next edge loads a fresh byte instead of shifting.
  assign load_edge = (bit_cnt_q == 3'd7);

  // Next-state logic for the shifter, bit counter, sync counter and the 2-state FSM.
  always_comb begin
    state_d    = state_q;
    sh_d       = {sh_q[6:0], 1'b0};
    bit_cnt_d  = bit_cnt_q + 3'd1;
    sync_cnt_d = sync_cnt_q;
    active_d   = active_q;

    if (load_edge) begin
      unique case (state_q)
        StSync: begin
          sh_d       = COM;
          sync_cnt_d = sync_cnt_q + 4'd1;
          if (sync_cnt_q == SyncLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          // Nothing is queued: without valid_in the slot is filled with a comma.
          sh_d     = valid_in ? data_in : COM;
          active_d = 1'b1;
        end
        default: begin
          state_d = StSync;
        end
      endcase
    end
  end

  // State registers; reset restarts the whole sync sequence and drops any partial byte.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= StSync;
      sh_q       <= 8'h00;
      bit_cnt_q  <= 3'd7;
      sync_cnt_q <= 4'd0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      active_q   <= active_d;
    end
  end

  // Outputs come straight from registers; ready never depends on inputs.
  always_comb begin
    ready    = (state_q == StRun) && load_edge;
    data_out = sh_q[7];
    active   = active_q;
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: sync burst, payload, filler, asynchronous reset mid-byte.
module tb_paralelo_serial;

  localparam logic [7:0] Com = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;
  logic       data_out;
  logic       active;

  int total = 0;
  int bad   = 0;

  paralelo_serial #(
    .COM       (8'hBC),
    .SYNC_COUNT(4)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .ready   (ready),
    .data_out(data_out),
    .active  (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  // Eight edges of one byte slot: checks each serial bit, active, and the single ready pulse.
  task automatic run_byte(input string tag, input logic [7:0] exp_byte, input logic exp_active,
                          input logic exp_ready_end);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq({tag, " bit"}, 32'(data_out), 32'(exp_byte[7-k]));
      check_eq({tag, " active"}, 32'(active), 32'(exp_active));
      check_eq({tag, " ready"}, 32'(ready), (k == 7) ? 32'(exp_ready_end) : 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'hFF;

    // 1: held in reset, inputs must have no effect.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rst outs", {29'd0, ready, active, data_out}, 32'd0);
    end

    // 2: release between edges; four commas, ready only before edge 33.
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    check_eq("post-rel ready", 32'(ready), 32'd0);
    run_byte("sync0", Com, 1'b0, 1'b0);
    run_byte("sync1", Com, 1'b0, 1'b0);
    run_byte("sync2", Com, 1'b0, 1'b0);
    run_byte("sync3", Com, 1'b0, 1'b1);

    // 3/4: back-to-back payload A5, 3C, FF.
    valid_in = 1'b1;
    data_in  = 8'hA5;
    run_byte("pay a5", 8'hA5, 1'b1, 1'b1);
    data_in  = 8'h3C;
    run_byte("pay 3c", 8'h3C, 1'b1, 1'b1);
    data_in  = 8'hFF;
    run_byte("pay ff", 8'hFF, 1'b1, 1'b1);

    // 5: three idle slots filled with commas; data_in ignored without valid.
    valid_in = 1'b0;
    data_in  = 8'h00;
    run_byte("fill0", Com, 1'b1, 1'b1);
    run_byte("fill1", Com, 1'b1, 1'b1);
    run_byte("fill2", Com, 1'b1, 1'b1);

    // 6: start A5 then reset asynchronously while bit 3 (a 0) ... use bit 3 of A5 = 0, bit 4 = 0.
    valid_in = 1'b1;
    data_in  = 8'hA5;
    tick();
    check_eq("abort b7", 32'(data_out), 32'd1);
    valid_in = 1'b0;
    tick();
    check_eq("abort b6", 32'(data_out), 32'd0);
    tick();
    check_eq("abort b5", 32'(data_out), 32'd1);
    tick();
    check_eq("abort b4", 32'(data_out), 32'd0);
    tick();
    check_eq("abort b3", 32'(data_out), 32'd0);
    tick();
    check_eq("abort b2", 32'(data_out), 32'd1);
    // Reset lands mid-cycle while a 1 is on the line, so the drop is visible without an edge.
    #2;
    reset = 1'b0;
    #1;
    check_eq("async data_out", 32'(data_out), 32'd0);
    check_eq("async active", 32'(active), 32'd0);
    check_eq("async ready", 32'(ready), 32'd0);
    tick();
    tick();
    check_eq("rst2 outs", {29'd0, ready, active, data_out}, 32'd0);

    // Full sync burst again, then a filler comma: the aborted byte is not resent.
    reset = 1'b1;
    #1;
    run_byte("resync0", Com, 1'b0, 1'b0);
    run_byte("resync1", Com, 1'b0, 1'b0);
    run_byte("resync2", Com, 1'b0, 1'b0);
    run_byte("resync3", Com, 1'b0, 1'b1);
    run_byte("refill", Com, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
